// File: rtl/make_next_reg.sv
// Single-step next-state generator for a small IA-32 subset: decodes the instruction at eip and
// produces the next architectural registers, flags and an optional dword store request.
module make_next_reg (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [5:0][7:0]  around_eip,
  input  logic [31:0]      eax,
  input  logic [31:0]      ecx,
  input  logic [31:0]      edx,
  input  logic [31:0]      ebx,
  input  logic [31:0]      esp,
  input  logic [31:0]      ebp,
  input  logic [31:0]      esi,
  input  logic [31:0]      edi,
  input  logic [31:0]      eip,
  input  logic             cf,
  input  logic             zf,
  input  logic             sf,
  input  logic             of,
  input  logic [31:0]      memval_m_reg,
  input  logic [31:0]      memval_m_reg_plus_imm8,
  input  logic [31:0]      memval_m_reg_plus_imm32,
  input  logic [31:0]      stack_value,
  input  logic [31:0]      ebp_leave_value,
  output logic [31:0]      m_reg,
  output logic [31:0]      m_reg_plus_imm8,
  output logic [31:0]      m_reg_plus_imm32,
  output logic             write_flag,
  output logic [31:0]      write_addr,
  output logic [31:0]      write_value,
  output logic [31:0]      next_eax,
  output logic [31:0]      next_ecx,
  output logic [31:0]      next_edx,
  output logic [31:0]      next_ebx,
  output logic [31:0]      next_esp,
  output logic [31:0]      next_ebp,
  output logic [31:0]      next_esi,
  output logic [31:0]      next_edi,
  output logic [31:0]      next_eip,
  output logic             next_cf,
  output logic             next_zf,
  output logic             next_sf,
  output logic             next_of,
  output logic             halted
);

  logic [7:0]  opcode;
  logic [31:0] imm8, imm32, disp8, disp32, r_reg;
  logic [1:0]  mod;
  logic [2:0]  r, m;
  logic [31:0] regs  [8];
  logic [31:0] nregs [8];
  logic [31:0] neip, waddr, wval;
  logic [3:0]  nflags;
  logic        wflag, hlt_dec, halted_q;

  // Result packed as {cf, zf, sf, of, res[31:0]}; sub also serves cmp.
  function automatic logic [35:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic sub);
    logic [32:0] s;
    logic        v;
    if (sub) begin
      s = {1'b0, a} - {1'b0, b};
      v = (a[31] != b[31]) && (s[31] != a[31]);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      v = (a[31] == b[31]) && (s[31] != a[31]);
    end
    return {s[32], (s[31:0] == 32'd0), s[31], v, s[31:0]};
  endfunction

  assign opcode = around_eip[0];
  assign imm8   = {{24{around_eip[1][7]}}, around_eip[1]};
  assign imm32  = {around_eip[4], around_eip[3], around_eip[2], around_eip[1]};
  assign disp8  = {{24{around_eip[2][7]}}, around_eip[2]};
  assign disp32 = {around_eip[5], around_eip[4], around_eip[3], around_eip[2]};
  assign mod    = around_eip[1][7:6];
  assign r      = around_eip[1][5:3];
  assign m      = around_eip[1][2:0];

  always_comb begin
    regs[0] = eax;
    regs[1] = ecx;
    regs[2] = edx;
    regs[3] = ebx;
    regs[4] = esp;
    regs[5] = ebp;
    regs[6] = esi;
    regs[7] = edi;
  end

  assign r_reg            = regs[r];
  assign m_reg            = regs[m];
  assign m_reg_plus_imm8  = m_reg + disp8;
  assign m_reg_plus_imm32 = m_reg + disp32;

  always_comb begin
    logic [35:0] alu_out;
    logic [2:0]  low;
    nregs   = regs;
    neip    = eip;
    nflags  = {cf, zf, sf, of};
    wflag   = 1'b0;
    waddr   = 32'd0;
    wval    = 32'd0;
    hlt_dec = 1'b0;
    alu_out = 36'd0;
    low     = opcode[2:0];
    case (opcode[7:3])
      5'b10111: begin  // b8+r
        nregs[low] = imm32;
        neip       = eip + 32'd5;
      end
      5'b01010: begin  // 50+r
        nregs[4] = esp - 32'd4;
        wflag    = 1'b1;
        waddr    = esp - 32'd4;
        wval     = regs[low];
        neip     = eip + 32'd1;
      end
      5'b01011: begin  // 58+r; assigned after esp so pop esp keeps the loaded value
        nregs[4]   = esp + 32'd4;
        nregs[low] = stack_value;
        neip       = eip + 32'd1;
      end
      default: begin
        case (opcode)
          8'h89, 8'h8b: begin
            if (mod == 2'b00 && (m == 3'd4 || m == 3'd5)) begin
              hlt_dec = 1'b1;
            end else begin
              if (opcode == 8'h89) begin
                if (mod == 2'b11) begin
                  nregs[m] = r_reg;
                end else begin
                  wflag = 1'b1;
                  wval  = r_reg;
                  waddr = (mod == 2'b00) ? m_reg :
                          (mod == 2'b01) ? m_reg_plus_imm8 : m_reg_plus_imm32;
                end
              end else begin
                nregs[r] = (mod == 2'b11) ? m_reg :
                           (mod == 2'b00) ? memval_m_reg :
                           (mod == 2'b01) ? memval_m_reg_plus_imm8 : memval_m_reg_plus_imm32;
              end
              neip = eip + ((mod == 2'b01) ? 32'd3 : (mod == 2'b10) ? 32'd6 : 32'd2);
            end
          end
          8'h01, 8'h29, 8'h39: begin
            if (mod == 2'b11) begin
              alu_out = alu(m_reg, r_reg, opcode != 8'h01);
              if (opcode != 8'h39) nregs[m] = alu_out[31:0];
              nflags = alu_out[35:32];
              neip   = eip + 32'd2;
            end else begin
              hlt_dec = 1'b1;
            end
          end
          8'h83: begin
            if (mod == 2'b11 && (r == 3'd0 || r == 3'd5 || r == 3'd7)) begin
              alu_out = alu(m_reg, disp8, r != 3'd0);
              if (r != 3'd7) nregs[m] = alu_out[31:0];
              nflags = alu_out[35:32];
              neip   = eip + 32'd3;
            end else begin
              hlt_dec = 1'b1;
            end
          end
          8'heb: neip = eip + 32'd2 + imm8;
          8'he9: neip = eip + 32'd5 + imm32;
          8'h74: neip = eip + 32'd2 + (zf ? imm8 : 32'd0);
          8'h7f: neip = eip + 32'd2 + ((!zf && sf == of) ? imm8 : 32'd0);
          8'he8: begin
            nregs[4] = esp - 32'd4;
            wflag    = 1'b1;
            waddr    = esp - 32'd4;
            wval     = eip + 32'd5;
            neip     = eip + 32'd5 + imm32;
          end
          8'hc3: begin
            neip     = stack_value;
            nregs[4] = esp + 32'd4;
          end
          8'hc9: begin
            nregs[4] = ebp + 32'd4;
            nregs[5] = ebp_leave_value;
            neip     = eip + 32'd1;
          end
          default: hlt_dec = 1'b1;  // f4 and every unsupported encoding
        endcase
      end
    endcase
    if (hlt_dec || halted_q) begin
      nregs  = regs;
      neip   = eip;
      nflags = {cf, zf, sf, of};
      wflag  = 1'b0;
    end
    if (RESET) wflag = 1'b0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      halted_q <= 1'b0;
    end else if (hlt_dec) begin
      halted_q <= 1'b1;
    end
  end

  assign halted      = halted_q;
  assign write_flag  = wflag;
  assign write_addr  = waddr;
  assign write_value = wval;
  assign next_eax    = nregs[0];
  assign next_ecx    = nregs[1];
  assign next_edx    = nregs[2];
  assign next_ebx    = nregs[3];
  assign next_esp    = nregs[4];
  assign next_ebp    = nregs[5];
  assign next_esi    = nregs[6];
  assign next_edi    = nregs[7];
  assign next_eip    = neip;
  assign {next_cf, next_zf, next_sf, next_of} = nflags;

endmodule

// File: tb/tb_make_next_reg.sv
// Directed, table-driven bench for make_next_reg: per-instruction vectors plus halt/reset sequences.
module tb_make_next_reg;

  logic            CLOCK = 1'b0;
  logic            RESET;
  logic [5:0][7:0] around_eip;
  logic [31:0]     eax, ecx, edx, ebx, esp, ebp, esi, edi, eip;
  logic            cf, zf, sf, of;
  logic [31:0]     memval_m_reg, memval_m_reg_plus_imm8, memval_m_reg_plus_imm32;
  logic [31:0]     stack_value, ebp_leave_value;
  logic [31:0]     m_reg, m_reg_plus_imm8, m_reg_plus_imm32;
  logic            write_flag;
  logic [31:0]     write_addr, write_value;
  logic [31:0]     next_eax, next_ecx, next_edx, next_ebx, next_esp, next_ebp, next_esi, next_edi;
  logic [31:0]     next_eip;
  logic            next_cf, next_zf, next_sf, next_of, halted;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK = ~CLOCK;

  make_next_reg dut (
    .CLOCK(CLOCK), .RESET(RESET), .around_eip(around_eip),
    .eax(eax), .ecx(ecx), .edx(edx), .ebx(ebx), .esp(esp), .ebp(ebp), .esi(esi), .edi(edi),
    .eip(eip), .cf(cf), .zf(zf), .sf(sf), .of(of),
    .memval_m_reg(memval_m_reg), .memval_m_reg_plus_imm8(memval_m_reg_plus_imm8),
    .memval_m_reg_plus_imm32(memval_m_reg_plus_imm32),
    .stack_value(stack_value), .ebp_leave_value(ebp_leave_value),
    .m_reg(m_reg), .m_reg_plus_imm8(m_reg_plus_imm8), .m_reg_plus_imm32(m_reg_plus_imm32),
    .write_flag(write_flag), .write_addr(write_addr), .write_value(write_value),
    .next_eax(next_eax), .next_ecx(next_ecx), .next_edx(next_edx), .next_ebx(next_ebx),
    .next_esp(next_esp), .next_ebp(next_ebp), .next_esi(next_esi), .next_edi(next_edi),
    .next_eip(next_eip), .next_cf(next_cf), .next_zf(next_zf), .next_sf(next_sf),
    .next_of(next_of), .halted(halted)
  );

  // flg/nflg are {cf, zf, sf, of}; ri/rv name one next register to check.
  typedef struct {
    logic [47:0] bytes;
    logic [31:0] eip, eax, edx, esp, ebp;
    logic [3:0]  flg;
    int          ri;
    logic [31:0] rv, neip;
    logic        wf;
    logic [31:0] wa, wv;
    logic [3:0]  nflg;
  } vec_t;

  function automatic logic [47:0] b6(input logic [7:0] b0, b1, b2, b3, b4, b5);
    return {b5, b4, b3, b2, b1, b0};
  endfunction

  function automatic vec_t mk(input logic [47:0] bytes, input logic [31:0] ip, a, d, sp, bp,
                              input logic [3:0] flg, input int ri, input logic [31:0] rv, neip,
                              input logic wf, input logic [31:0] wa, wv, input logic [3:0] nflg);
    vec_t v;
    v.bytes = bytes; v.eip = ip; v.eax = a; v.edx = d; v.esp = sp; v.ebp = bp; v.flg = flg;
    v.ri = ri; v.rv = rv; v.neip = neip; v.wf = wf; v.wa = wa; v.wv = wv; v.nflg = nflg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] next_reg(input int i);
    case (i)
      0: return next_eax;
      1: return next_ecx;
      2: return next_edx;
      3: return next_ebx;
      4: return next_esp;
      5: return next_ebp;
      6: return next_esi;
      default: return next_edi;
    endcase
  endfunction

  task automatic apply(input vec_t v);
    around_eip = v.bytes;
    eip = v.eip; eax = v.eax; edx = v.edx; esp = v.esp; ebp = v.ebp;
    {cf, zf, sf, of} = v.flg;
  endtask

  task automatic expect_halt_after(input string name, input logic [47:0] bytes);
    RESET = 1'b0;
    around_eip = bytes;
    eip = 32'h200;
    @(negedge CLOCK);
    check({name, " eip held"}, next_eip, 32'h200);
    check({name, " no write"}, {31'd0, write_flag}, 32'd0);
    @(posedge CLOCK); #2;
    check({name, " halted"}, {31'd0, halted}, 32'd1);
    RESET = 1'b1;
    @(posedge CLOCK); #2;
    RESET = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    ecx = 32'h100; ebx = 32'h200; esi = 32'h6; edi = 32'h7;
    memval_m_reg = 32'haaaa0000; memval_m_reg_plus_imm8 = 32'hbbbb0000;
    memval_m_reg_plus_imm32 = 32'hcccc0000;
    stack_value = 32'h12345678; ebp_leave_value = 32'h0badf00d;

    // Reset with a push presented: store must be suppressed while RESET is high.
    RESET = 1'b1;
    apply(mk(b6(8'h50, 0, 0, 0, 0, 0), 32'hd, 32'ha, 0, 32'h300, 32'h2f0, 4'b0, 4,
             0, 0, 0, 0, 0, 0));
    @(posedge CLOCK); #2;
    @(negedge CLOCK);
    check("reset halted", {31'd0, halted}, 32'd0);
    check("reset write_flag", {31'd0, write_flag}, 32'd0);
    check("reset next_esp comb", next_esp, 32'h2fc);
    @(posedge CLOCK); #2;
    RESET = 1'b0;

    vecs.push_back(mk(b6(8'hb8, 8'h0a, 0, 0, 0, 0), 32'h08, 0, 0, 32'h300, 32'h2f0, 4'b0000,
                      0, 32'ha, 32'h0d, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h50, 0, 0, 0, 0, 0), 32'h0d, 32'ha, 0, 32'h300, 32'h2f0, 4'b0000,
                      4, 32'h2fc, 32'h0e, 1, 32'h2fc, 32'ha, 4'b0000));
    vecs.push_back(mk(b6(8'he8, 8'h0f, 0, 0, 0, 0), 32'h0e, 32'ha, 0, 32'h2fc, 32'h2f0, 4'b0000,
                      4, 32'h2f8, 32'h22, 1, 32'h2f8, 32'h13, 4'b0000));
    vecs.push_back(mk(b6(8'h39, 8'hd0, 0, 0, 0, 0), 32'h40, 2, 2, 32'h300, 32'h2f0, 4'b1011,
                      0, 2, 32'h42, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(b6(8'h74, 8'h36, 0, 0, 0, 0), 32'h49, 2, 2, 32'h300, 32'h2f0, 4'b0100,
                      0, 2, 32'h81, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(b6(8'h74, 8'h36, 0, 0, 0, 0), 32'h49, 2, 2, 32'h300, 32'h2f0, 4'b0000,
                      0, 2, 32'h4b, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h89, 8'h45, 8'hfc, 0, 0, 0), 32'h50, 5, 0, 32'h300, 32'h2f0, 4'b0000,
                      5, 32'h2f0, 32'h53, 1, 32'h2ec, 5, 4'b0000));
    vecs.push_back(mk(b6(8'h01, 8'hd0, 0, 0, 0, 0), 32'h60, 32'hffffffff, 1, 32'h300, 32'h2f0,
                      4'b0000, 0, 0, 32'h62, 0, 0, 0, 4'b1100));
    vecs.push_back(mk(b6(8'h29, 8'hd0, 0, 0, 0, 0), 32'h60, 32'h80000000, 1, 32'h300, 32'h2f0,
                      4'b0000, 0, 32'h7fffffff, 32'h62, 0, 0, 0, 4'b0001));
    vecs.push_back(mk(b6(8'h83, 8'he8, 8'h05, 0, 0, 0), 32'h60, 3, 0, 32'h300, 32'h2f0, 4'b0000,
                      0, 32'hfffffffe, 32'h63, 0, 0, 0, 4'b1010));
    vecs.push_back(mk(b6(8'h83, 8'hc0, 8'hff, 0, 0, 0), 32'h60, 32'h10, 0, 32'h300, 32'h2f0,
                      4'b0000, 0, 32'hf, 32'h63, 0, 0, 0, 4'b1000));
    vecs.push_back(mk(b6(8'h83, 8'hf8, 8'h05, 0, 0, 0), 32'h60, 5, 0, 32'h300, 32'h2f0, 4'b1011,
                      0, 5, 32'h63, 0, 0, 0, 4'b0100));
    vecs.push_back(mk(b6(8'h5a, 0, 0, 0, 0, 0), 32'h70, 0, 9, 32'h2f8, 32'h2f0, 4'b0000,
                      2, 32'h12345678, 32'h71, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h5a, 0, 0, 0, 0, 0), 32'h70, 0, 9, 32'h2f8, 32'h2f0, 4'b0000,
                      4, 32'h2fc, 32'h71, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h5c, 0, 0, 0, 0, 0), 32'h70, 0, 0, 32'h2f8, 32'h2f0, 4'b0000,
                      4, 32'h12345678, 32'h71, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'hc3, 0, 0, 0, 0, 0), 32'h60, 0, 0, 32'h2f8, 32'h2f0, 4'b0000,
                      4, 32'h2fc, 32'h12345678, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'hc9, 0, 0, 0, 0, 0), 32'h80, 0, 0, 32'h100, 32'h2f0, 4'b0000,
                      4, 32'h2f4, 32'h81, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'hc9, 0, 0, 0, 0, 0), 32'h80, 0, 0, 32'h100, 32'h2f0, 4'b0000,
                      5, 32'h0badf00d, 32'h81, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h8b, 8'h83, 8'h10, 0, 0, 0), 32'h90, 0, 0, 32'h300, 32'h2f0, 4'b0000,
                      0, 32'hcccc0000, 32'h96, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h8b, 8'h0b, 0, 0, 0, 0), 32'h90, 0, 0, 32'h300, 32'h2f0, 4'b0000,
                      1, 32'haaaa0000, 32'h92, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h8b, 8'h4b, 8'h04, 0, 0, 0), 32'h90, 0, 0, 32'h300, 32'h2f0, 4'b0000,
                      1, 32'hbbbb0000, 32'h93, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h7f, 8'h10, 0, 0, 0, 0), 32'h70, 0, 0, 32'h300, 32'h2f0, 4'b0000,
                      0, 0, 32'h82, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h7f, 8'h10, 0, 0, 0, 0), 32'h70, 0, 0, 32'h300, 32'h2f0, 4'b0010,
                      0, 0, 32'h72, 0, 0, 0, 4'b0010));
    vecs.push_back(mk(b6(8'h7f, 8'h10, 0, 0, 0, 0), 32'h70, 0, 0, 32'h300, 32'h2f0, 4'b0011,
                      0, 0, 32'h82, 0, 0, 0, 4'b0011));
    vecs.push_back(mk(b6(8'heb, 8'hfe, 0, 0, 0, 0), 32'h90, 0, 0, 32'h300, 32'h2f0, 4'b0000,
                      0, 0, 32'h90, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'he9, 8'hf0, 8'hff, 8'hff, 8'hff, 0), 32'h100, 0, 0, 32'h300, 32'h2f0,
                      4'b0000, 0, 0, 32'hf5, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h89, 8'hc2, 0, 0, 0, 0), 32'h90, 32'h55, 3, 32'h300, 32'h2f0, 4'b0000,
                      2, 32'h55, 32'h92, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(b6(8'h89, 8'h83, 8'h00, 8'h01, 0, 0), 32'h90, 32'h77, 0, 32'h300, 32'h2f0,
                      4'b0000, 0, 32'h77, 32'h96, 1, 32'h300, 32'h77, 4'b0000));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d op %02h", i, vecs[i].bytes[7:0]);
      @(posedge CLOCK); #2;
      apply(vecs[i]);
      @(negedge CLOCK);
      check({tag, " next_eip"}, next_eip, vecs[i].neip);
      check({tag, " write_flag"}, {31'd0, write_flag}, {31'd0, vecs[i].wf});
      if (vecs[i].wf) begin
        check({tag, " write_addr"}, write_addr, vecs[i].wa);
        check({tag, " write_value"}, write_value, vecs[i].wv);
      end
      check({tag, " next_reg"}, next_reg(vecs[i].ri), vecs[i].rv);
      check({tag, " flags"}, {28'd0, next_cf, next_zf, next_sf, next_of}, {28'd0, vecs[i].nflg});
      check({tag, " halted"}, {31'd0, halted}, 32'd0);
    end

    // Effective-address outputs for 89 45 fc with ebp=0x2f0.
    @(posedge CLOCK); #2;
    apply(vecs[6]);
    @(negedge CLOCK);
    check("m_reg", m_reg, 32'h2f0);
    check("m_reg_plus_imm8", m_reg_plus_imm8, 32'h2ec);
    around_eip = b6(8'h8b, 8'h83, 8'h10, 8'h00, 8'h00, 8'h00);
    #1;
    check("m_reg_plus_imm32", m_reg_plus_imm32, 32'h210);

    // hlt: latches on the next edge, then everything holds.
    @(posedge CLOCK); #2;
    apply(mk(b6(8'hf4, 0, 0, 0, 0, 0), 32'h40, 1, 0, 32'h300, 32'h2f0, 4'b0000,
             0, 0, 0, 0, 0, 0, 0));
    @(negedge CLOCK);
    check("hlt before edge halted", {31'd0, halted}, 32'd0);
    check("hlt eip held", next_eip, 32'h40);
    @(posedge CLOCK); #2;
    check("hlt halted", {31'd0, halted}, 32'd1);
    apply(mk(b6(8'h50, 0, 0, 0, 0, 0), 32'h41, 32'ha, 0, 32'h300, 32'h2f0, 4'b0000,
             0, 0, 0, 0, 0, 0, 0));
    @(negedge CLOCK);
    check("halted push write_flag", {31'd0, write_flag}, 32'd0);
    check("halted push esp", next_esp, 32'h300);
    check("halted push eip", next_eip, 32'h41);
    @(posedge CLOCK); #2;
    check("halted sticky", {31'd0, halted}, 32'd1);
    // RESET beats a simultaneous hlt.
    around_eip = b6(8'hf4, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    @(posedge CLOCK); #2;
    check("reset over hlt", {31'd0, halted}, 32'd0);
    RESET = 1'b0;
    @(posedge CLOCK); #2;
    RESET = 1'b1;
    @(posedge CLOCK); #2;
    RESET = 1'b0;

    expect_halt_after("unknown 90", b6(8'h90, 0, 0, 0, 0, 0));
    expect_halt_after("89 mod00 m4", b6(8'h89, 8'h04, 0, 0, 0, 0));
    expect_halt_after("8b mod00 m5", b6(8'h8b, 8'h05, 0, 0, 0, 0));
    expect_halt_after("83 /1", b6(8'h83, 8'hc8, 8'h01, 0, 0, 0));
    expect_halt_after("01 mod01", b6(8'h01, 8'h50, 8'h04, 0, 0, 0));
    check("final halted cleared", {31'd0, halted}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/make_next_reg.md
MAKE_NEXT_REG -- requirements
Module: make_next_reg

Interface
REQ-001 CLOCK  input  1  sole clock, rising-edge.
REQ-002 RESET  input  1  synchronous, active-high reset.
REQ-003 around_eip  input  6x8  bytes memory[eip+0..eip+5]; byte 0 is the opcode.
REQ-004 eax,ecx,edx,ebx,esp,ebp,esi,edi,eip  input  32 each  current architectural registers.
REQ-005 cf,zf,sf,of  input  1 each  current flags.
REQ-006 memval_m_reg, memval_m_reg_plus_imm8, memval_m_reg_plus_imm32  input  32 each  little-endian dwords at the matching m_reg* addresses.
REQ-007 stack_value, ebp_leave_value  input  32 each  little-endian dwords at [esp] and [ebp].
REQ-008 m_reg, m_reg_plus_imm8, m_reg_plus_imm32  output  32 each  effective addresses for the memval_* fetches.
REQ-009 write_flag, write_addr, write_value  output  1/32/32  one dword store request, little-endian, committed by the parent on the next CLOCK edge.
REQ-010 next_eax..next_edi, next_eip  output  32 each; next_cf..next_of  output  1 each  combinational next state.
REQ-011 halted  output  1  registered halt status.

Function
REQ-012 Decode fields: imm8 = sext(byte1); imm32 = bytes1..4; mod = byte1[7:6], r = byte1[5:3], m = byte1[2:0]; disp8 = sext(byte2); disp32 = bytes2..5.
REQ-013 Register index order: 0=eax, 1=ecx, 2=edx, 3=ebx, 4=esp, 5=ebp, 6=esi, 7=edi.
REQ-014 r_reg = reg[r]; m_reg = reg[m]; m_reg_plus_imm8 = m_reg+disp8; m_reg_plus_imm32 = m_reg+disp32.
REQ-015 Defaults: every next_* equals its current value and write_flag = 0.
REQ-016 All arithmetic is 32-bit and wraps modulo 2^32.
REQ-017 b8+r: reg[r] = imm32; eip += 5.
REQ-018 50+r push: esp -= 4; store reg[r] at esp-4; eip += 1.
REQ-019 58+r pop: reg[r] = stack_value; esp += 4; eip += 1; for pop esp the loaded value wins.
REQ-020 89 mov r/m32,r32 with mod 11: reg[m] = r_reg.
REQ-021 89 with mod 00/01/10: store r_reg at m_reg / m_reg+disp8 / m_reg+disp32.
REQ-022 8b mov r32,r/m32: reg[r] = m_reg (mod 11), memval_m_reg (00), memval_m_reg_plus_imm8 (01) or memval_m_reg_plus_imm32 (10).
REQ-023 Length of 89/8b: 2 (mod 00/11), 3 (01), 6 (10); mod 00 with m=4 or m=5 is illegal.
REQ-024 01 add, 29 sub, 39 cmp (mod 11 only): reg[m] op r_reg; cmp discards the result; eip += 2.
REQ-025 83 /0 add, /5 sub, /7 cmp with imm (mod 11 only): reg[m] op sext(byte2); eip += 3.
REQ-026 Flags for add/sub/cmp: zf = (res==0); sf = res[31]; cf = carry-out (add) or borrow (sub/cmp); of = signed overflow; no other instruction changes flags.
REQ-027 eb: eip += 2+imm8.
REQ-028 e9: eip += 5+imm32.
REQ-029 74 je: eip += 2+imm8 if zf, else eip += 2.
REQ-030 7f jg: eip += 2+imm8 if (!zf && sf==of), else eip += 2.
REQ-031 e8 call: esp -= 4; store eip+5 at esp-4; eip += 5+imm32.
REQ-032 c3 ret: eip = stack_value; esp += 4.
REQ-033 c9 leave: esp = ebp+4; ebp = ebp_leave_value; eip += 1.
REQ-034 f4 hlt: eip unchanged; halted set to 1 on the next CLOCK edge.
REQ-035 Unknown opcode, unsupported /digit, or illegal mod is treated as hlt.
REQ-036 While halted = 1: all next_* hold their current values and write_flag = 0.

Reset
REQ-037 RESET high at a CLOCK edge clears halted to 0; RESET has priority over hlt in the same cycle.
REQ-038 While RESET is high, write_flag = 0; other outputs stay combinational.
REQ-039 Outputs are valid once halted is defined after the first reset edge.

Verification
REQ-040 mov imm: eip=0x08, bytes b8 0a 00 00 00 -> next_eax=0x0000000a, next_eip=0x0d, write_flag=0.
REQ-041 push: eip=0x0d, esp=0x300, eax=0xa, byte 50 -> write_flag=1, write_addr=0x2fc, write_value=0xa, next_esp=0x2fc, next_eip=0x0e.
REQ-042 call: eip=0x0e, esp=0x2fc, bytes e8 0f 00 00 00 -> write_addr=0x2f8, write_value=0x13, next_esp=0x2f8, next_eip=0x22.
REQ-043 cmp then je: eax=2, edx=2, bytes 39 d0 -> zf=1, sf=cf=of=0, eip+2; then with zf=1, eip=0x49, bytes 74 36 -> next_eip=0x81.
REQ-044 mov store: ebp=0x2f0, eax=5, bytes 89 45 fc -> m_reg_plus_imm8=0x2ec, write_addr=0x2ec, write_value=5, eip+3.
REQ-045 hlt: byte f4 -> halted=1 after one edge, eip held, write_flag=0 thereafter; then RESET for one edge -> halted=0.
